// File: rtl/serial_add_arbiter_if.sv
// Requester-facing bundle of serial_add_arbiter: request/operand lines in,
// grant, status and result out.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [WIDTH:0]         sum_out;

    modport master (
        output req, a_in, b_in,
        input  gnt, busy, done, done_id, sum_out
    );

    modport slave (
        input  req, a_in, b_in,
        output gnt, busy, done, done_id, sum_out
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Shares one bit-serial adder between N_REQ requesters via round-robin arbitration.
// Optional macro SA_FIXED_PRI_EN: lowest requesting index always wins (no pointer).
module serial_add_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input logic                 clk,
    input logic                 reset,
    serial_add_arbiter_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [IDW-1:0]   idx;
    logic [IDW-1:0]   pick;
    logic             pick_vld;

    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] sum_sr;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic             fa_s;
    logic             fa_c;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    logic [WIDTH:0]   sum_q;
    logic [IDW-1:0]   done_id_q;
    logic [N_REQ-1:0] gnt_d;
    logic             busy_d;
    logic             done_d;

`ifndef SA_FIXED_PRI_EN
    logic [IDW-1:0]   ptr;
    int unsigned      rr_j;
`endif

    // Winner selection from the live request vector; only consumed in IDLE.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
`ifdef SA_FIXED_PRI_EN
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (bus.req[IDW'(i - 1)]) begin
                pick     = IDW'(i - 1);
                pick_vld = 1'b1;
            end
        end
`else
        rr_j = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rr_j = 32'(ptr) + k;
            if (rr_j >= N_REQ) begin
                rr_j = rr_j - N_REQ;
            end
            if (!pick_vld && bus.req[IDW'(rr_j)]) begin
                pick     = IDW'(rr_j);
                pick_vld = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (idx == IDW'(i)) begin
                a_sel = bus.a_in[i*WIDTH +: WIDTH];
                b_sel = bus.b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
    assign fa_c     = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // SIPO keeps WIDTH-1 bits; the final sum bit and carry go straight into
    // sum_out on the last shift so the result is valid during DONE.
    assign sum_nxt  = {fa_s, sum_sr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_d     = '0;
        busy_d    = 1'b1;
        done_d    = 1'b0;
        unique case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (pick_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                gnt_d[idx] = 1'b1;
                state_nxt  = SHIFT;
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            a_sr      <= '0;
            b_sr      <= '0;
            sum_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_q     <= '0;
            done_id_q <= '0;
`ifndef SA_FIXED_PRI_EN
            ptr       <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        idx <= pick;
`ifndef SA_FIXED_PRI_EN
                        ptr <= (pick == IDW'(N_REQ - 1)) ? '0 : pick + IDW'(1);
`endif
                    end
                end
                LOAD: begin
                    a_sr  <= a_sel;
                    b_sr  <= b_sel;
                    carry <= 1'b0;
                    cnt   <= '0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    sum_sr <= sum_nxt[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_q     <= {fa_c, sum_nxt};
                        done_id_q <= idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = gnt_d;
    assign bus.busy    = busy_d;
    assign bus.done    = done_d;
    assign bus.done_id = done_id_q;
    assign bus.sum_out = sum_q;
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: cycle-timeline reference model
// plus directed scenarios with hand-computed results.
module tb_serial_add_arbiter;
    localparam int WIDTH = 8;
    localparam int N_REQ = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    serial_add_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

    serial_add_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: each grant fixes a timeline (LOAD, DONE, next free
    // cycle) and the sum is plain a+b of the operands present at LOAD.
    int             m_load  = -1;
    int             m_done  = -1;
    int             m_free  = 0;
    int             m_win   = 0;
    int             m_id    = 0;
    bit             m_valid = 1'b0;
    logic [WIDTH:0] m_pend  = '0;
    logic [WIDTH:0] m_sum   = '0;
`ifndef SA_FIXED_PRI_EN
    int             m_ptr   = 0;
`endif

    function automatic int model_pick(input logic [N_REQ-1:0] r);
`ifdef SA_FIXED_PRI_EN
        for (int k = 0; k < N_REQ; k++) begin
            if (r[k]) return k;
        end
`else
        for (int k = 0; k < N_REQ; k++) begin
            if (r[(m_ptr + k) % N_REQ]) return (m_ptr + k) % N_REQ;
        end
`endif
        return 0;
    endfunction

    always @(posedge clk) begin
        int c;
        c = cyc;
        if (reset) begin
            m_valid = 1'b1;
            m_load  = -1;
            m_done  = -1;
            m_free  = c + 1;
            m_sum   = '0;
            m_id    = 0;
`ifndef SA_FIXED_PRI_EN
            m_ptr   = 0;
`endif
        end else if (m_valid) begin
            if (c == m_load) begin
                m_pend = {1'b0, bus.a_in[m_win*WIDTH +: WIDTH]} + {1'b0, bus.b_in[m_win*WIDTH +: WIDTH]};
            end
            if (c == m_done - 1) begin
                m_sum = m_pend;
                m_id  = m_win;
            end
            if (c >= m_free && bus.req != '0) begin
                m_win  = model_pick(bus.req);
                m_load = c + 1;
                m_done = c + WIDTH + 2;
                m_free = c + WIDTH + 3;
`ifndef SA_FIXED_PRI_EN
                m_ptr  = (m_win + 1) % N_REQ;
`endif
            end
        end
        cyc = c + 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("gnt",     bus.gnt,     (cyc == m_load) ? (1 << m_win) : 0);
            check("busy",    bus.busy,    32'(cyc >= m_load && cyc <= m_done));
            check("done",    bus.done,    32'(cyc == m_done));
            check("sum_out", bus.sum_out, m_sum);
            check("done_id", bus.done_id, m_id);
        end
    end

    task automatic drive();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.a_in[i*WIDTH +: WIDTH] = a;
        bus.b_in[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt(output int t, output logic [N_REQ-1:0] g, input int limit);
        t = -1;
        g = '0;
        for (int k = 0; k < limit && t < 0; k++) begin
            sample();
            if (bus.gnt != '0) begin
                t = cyc;
                g = bus.gnt;
            end
        end
    endtask

    task automatic wait_done(output int t, input int limit);
        t = -1;
        for (int k = 0; k < limit && t < 0; k++) begin
            sample();
            if (bus.done) t = cyc;
        end
    endtask

    task automatic run_one(input string nm, input int id, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH:0] exp_sum);
        int t_req, t_g, t_d;
        logic [N_REQ-1:0] g;
        drive();
        set_op(id, a, b);
        bus.req     = '0;
        bus.req[id] = 1'b1;
        t_req = cyc;
        wait_gnt(t_g, g, 4);
        check({nm, "_gnt"}, g, 1 << id);
        check({nm, "_gnt_lat"}, t_g - t_req, 1);
        drive();
        bus.req = '0;
        wait_done(t_d, WIDTH + 6);
        check({nm, "_done_lat"}, t_d - t_req, 10);
        check({nm, "_sum"}, bus.sum_out, exp_sum);
        check({nm, "_id"}, bus.done_id, id);
    endtask

    int               t_g, t_d, t_g2, seen, ng, nd;
    logic [N_REQ-1:0] g;
    int               gcyc [5];
    logic [N_REQ-1:0] gval [5];
    int               did  [5];
    logic [WIDTH:0]   dsum [5];
    logic [N_REQ-1:0] exp_g   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [WIDTH:0]   exp_sum [5] = '{9'h011, 9'h100, 9'h110, 9'h100, 9'h011};

    initial begin
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) drive();
        reset = 1'b0;
        sample();
        check("rst_busy",    bus.busy,    0);
        check("rst_gnt",     bus.gnt,     0);
        check("rst_done",    bus.done,    0);
        check("rst_sum",     bus.sum_out, 0);
        check("rst_done_id", bus.done_id, 0);

        run_one("basic", 0, 8'hEB, 8'hFB, 9'h1E6);
        run_one("ff",    1, 8'hFF, 8'hFF, 9'h1FE);
        run_one("zero",  2, 8'h00, 8'h00, 9'h000);
        run_one("msb",   3, 8'h80, 8'h80, 9'h100);

        // Reset four cycles after the grant: result is discarded.
        drive();
        set_op(0, 8'h12, 8'h34);
        bus.req = 4'b0001;
        wait_gnt(t_g, g, 4);
        drive();
        bus.req = '0;
        repeat (2) drive();
        drive();
        reset = 1'b1;
        drive();
        reset = 1'b0;
        sample();
        check("midrst_busy", bus.busy,    0);
        check("midrst_gnt",  bus.gnt,     0);
        check("midrst_sum",  bus.sum_out, 0);
        check("midrst_done", bus.done,    0);
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            sample();
            if (bus.done) seen++;
        end
        check("midrst_no_done", seen, 0);

        // Reset together with a request: no grant afterwards.
        drive();
        reset   = 1'b1;
        bus.req = 4'b0001;
        drive();
        reset   = 1'b0;
        bus.req = '0;
        sample();
        check("rstreq_gnt",  bus.gnt,  0);
        check("rstreq_busy", bus.busy, 0);

        run_one("after_rst", 2, 8'h20, 8'h30, 9'h050);

        // Requests and operand changes during SHIFT are ignored.
        drive();
        set_op(1, 8'h5A, 8'h33);
        bus.req = 4'b0010;
        wait_gnt(t_g, g, 4);
        check("iso_gnt1", g, 4'b0010);
        drive();
        bus.req = '0;
        repeat (2) drive();
        bus.req = 4'b1000;
        set_op(3, 8'h01, 8'h02);
        set_op(1, 8'hFF, 8'hFF);
        wait_done(t_d, WIDTH + 6);
        check("iso_sum1", bus.sum_out, 9'h08D);
        check("iso_id1",  bus.done_id, 1);
        wait_gnt(t_g2, g, 4);
        check("iso_gnt3", g, 4'b1000);
        check("iso_gnt3_lat", t_g2 - t_d, 2);
        drive();
        bus.req = '0;
        wait_done(t_d, WIDTH + 6);
        check("iso_sum3", bus.sum_out, 9'h003);
        check("iso_id3",  bus.done_id, 3);

        // Fairness with all four requesting from a fresh pointer.
        drive();
        reset = 1'b1;
        drive();
        reset = 1'b0;
        set_op(0, 8'h10, 8'h01);
        set_op(1, 8'h9C, 8'h64);
        set_op(2, 8'hF0, 8'h20);
        set_op(3, 8'h7F, 8'h81);
        bus.req = 4'b1111;
        ng = 0;
        nd = 0;
        for (int k = 0; k < 80 && nd < 5; k++) begin
            sample();
            if (bus.gnt != '0 && ng < 5) begin
                gcyc[ng] = cyc;
                gval[ng] = bus.gnt;
                ng++;
            end
            if (bus.done && nd < 5) begin
                did[nd]  = int'(bus.done_id);
                dsum[nd] = bus.sum_out;
                nd++;
            end
        end
        drive();
        bus.req = '0;
        check("fair_ngnt",  ng, 5);
        check("fair_ndone", nd, 5);
        for (int i = 0; i < 5; i++) begin
`ifdef SA_FIXED_PRI_EN
            check("fair_gnt",  gval[i], 4'b0001);
            check("fair_id",   did[i],  0);
            check("fair_sum",  dsum[i], 9'h011);
`else
            check("fair_gnt",  gval[i], exp_g[i]);
            check("fair_id",   did[i],  i % 4);
            check("fair_sum",  dsum[i], exp_sum[i]);
`endif
            if (i > 0) check("fair_spacing", gcyc[i] - gcyc[i-1], 11);
        end

        // Two requesters held: alternation, or requester 1 only with fixed priority.
        drive();
        bus.req = 4'b1010;
        ng = 0;
        nd = 0;
        for (int k = 0; k < 60 && nd < 4; k++) begin
            sample();
            if (bus.gnt != '0 && ng < 4) begin
                gval[ng] = bus.gnt;
                ng++;
            end
            if (bus.done && nd < 4) begin
                did[nd] = int'(bus.done_id);
                nd++;
            end
        end
        drive();
        bus.req = '0;
        check("pair_ndone", nd, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef SA_FIXED_PRI_EN
            check("pair_gnt", gval[i], 4'b0010);
            check("pair_id",  did[i],  1);
`else
            check("pair_gnt", gval[i], (i % 2 == 0) ? 4'b0010 : 4'b1000);
            check("pair_id",  did[i],  (i % 2 == 0) ? 1 : 3);
`endif
        end

        repeat (14) drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d: got no finish expected finish", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
